jtag_tap_target: RTL

JTAG_TAP_TARGET -- requirements
Module: jtag_tap_target

---
 rtl/jtag_pkg.sv | 56 +++++
 rtl/jtag_tap_fsm.sv | 42 ++++
 rtl/jtag_tap_target.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, instruction codes, DR selection
// and the command codes the initiator side already uses.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_e;

  localparam logic [3:0] IR_ABORT   = 4'b1000;
  localparam logic [3:0] IR_DPACC   = 4'b1010;
  localparam logic [3:0] IR_APACC   = 4'b1011;
  localparam logic [3:0] IR_IDCODE  = 4'b1110;
  localparam logic [3:0] IR_BYPASS  = 4'b1111;
  localparam logic [3:0] IR_CAPTURE = 4'b0001;

  localparam logic [2:0] JTAG_CMD_NOP     = 3'd0;
  localparam logic [2:0] JTAG_CMD_RESET   = 3'd1;
  localparam logic [2:0] JTAG_CMD_IR_SCAN = 3'd2;
  localparam logic [2:0] JTAG_CMD_DR_SCAN = 3'd3;
  localparam logic [2:0] JTAG_CMD_READID  = 3'd4;

  typedef enum logic [2:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_DPACC,
    DR_APACC,
    DR_ABORT
  } dr_sel_e;

  // Unknown instruction codes fall back to the 1-bit bypass register.
  function automatic dr_sel_e dr_sel(input logic [3:0] ir_v);
    case (ir_v)
      IR_ABORT:  return DR_ABORT;
      IR_DPACC:  return DR_DPACC;
      IR_APACC:  return DR_APACC;
      IR_IDCODE: return DR_IDCODE;
      default:   return DR_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller, stepped once per advance strobe.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       tms,
  output logic [3:0] state
);

  tap_state_e r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TAP_TLR;
    end else if (advance) begin
      case (r_state)
        TAP_TLR:     r_state <= tms ? TAP_TLR     : TAP_RTI;
        TAP_RTI:     r_state <= tms ? TAP_SELDR   : TAP_RTI;
        TAP_SELDR:   r_state <= tms ? TAP_SELIR   : TAP_CAPDR;
        TAP_CAPDR:   r_state <= tms ? TAP_EX1DR   : TAP_SHDR;
        TAP_SHDR:    r_state <= tms ? TAP_EX1DR   : TAP_SHDR;
        TAP_EX1DR:   r_state <= tms ? TAP_UPDDR   : TAP_PAUSEDR;
        TAP_PAUSEDR: r_state <= tms ? TAP_EX2DR   : TAP_PAUSEDR;
        TAP_EX2DR:   r_state <= tms ? TAP_UPDDR   : TAP_SHDR;
        TAP_UPDDR:   r_state <= tms ? TAP_SELDR   : TAP_RTI;
        TAP_SELIR:   r_state <= tms ? TAP_TLR     : TAP_CAPIR;
        TAP_CAPIR:   r_state <= tms ? TAP_EX1IR   : TAP_SHIR;
        TAP_SHIR:    r_state <= tms ? TAP_EX1IR   : TAP_SHIR;
        TAP_EX1IR:   r_state <= tms ? TAP_UPDIR   : TAP_PAUSEIR;
        TAP_PAUSEIR: r_state <= tms ? TAP_EX2IR   : TAP_PAUSEIR;
        TAP_EX2IR:   r_state <= tms ? TAP_UPDIR   : TAP_SHIR;
        TAP_UPDIR:   r_state <= tms ? TAP_SELDR   : TAP_RTI;
        default:     r_state <= TAP_TLR;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: rtl/jtag_tap_target.sv
// JTAG-DP style TAP target running on the system clock: oversamples tck,
// shifts IR/DR, and turns DPACC/APACC/ABORT updates into one-clk pulses.
module jtag_tap_target
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h4BA00477,
  parameter int          IRLEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tck,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  output logic [3:0]  ir,
  output logic [3:0]  tap_state,
  output logic        req,
  output logic        req_apndp,
  output logic [1:0]  req_addr32,
  output logic        req_rnw,
  output logic [31:0] req_wdata,
  output logic        abort,
  input  logic [31:0] rdata,
  input  logic [2:0]  ack
);

  logic r_tck_s1, r_tck_s2, r_tck_d;
  logic r_tms_s1, r_tms_s2;
  logic r_tdi_s1, r_tdi_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tck_s1 <= 1'b0;
      r_tck_s2 <= 1'b0;
      r_tck_d  <= 1'b0;
      r_tms_s1 <= 1'b0;
      r_tms_s2 <= 1'b0;
      r_tdi_s1 <= 1'b0;
      r_tdi_s2 <= 1'b0;
    end else begin
      r_tck_s1 <= tck;
      r_tck_s2 <= r_tck_s1;
      r_tck_d  <= r_tck_s2;
      r_tms_s1 <= tms;
      r_tms_s2 <= r_tms_s1;
      r_tdi_s1 <= tdi;
      r_tdi_s2 <= r_tdi_s1;
    end
  end

  logic       w_rise, w_fall;
  logic [3:0] w_state_bits;
  tap_state_e w_state;

  assign w_rise = r_tck_s2 & ~r_tck_d;
  assign w_fall = ~r_tck_s2 & r_tck_d;

  // The FSM advances on the same clk that performs the current state's action.
  jtag_tap_fsm u_fsm (
    .clk     (clk),
    .rst     (rst),
    .advance (w_rise),
    .tms     (r_tms_s2),
    .state   (w_state_bits)
  );

  assign w_state = tap_state_e'(w_state_bits);

  logic [IRLEN-1:0] r_ir, r_ir_sr;
  logic [34:0]      r_dr;
  logic             r_tdo, r_req, r_abort, r_req_apndp, r_req_rnw;
  logic [1:0]       r_req_addr32;
  logic [31:0]      r_req_wdata;
  dr_sel_e          w_sel;
  logic [34:0]      w_dr_capture, w_dr_shift;

  assign w_sel = dr_sel(r_ir);

  always_comb begin
    w_dr_capture = 35'd0;
    case (w_sel)
      DR_IDCODE:          w_dr_capture = {3'b000, IDCODE};
      DR_DPACC, DR_APACC: w_dr_capture = {rdata, ack};
      default:            w_dr_capture = 35'd0;
    endcase
  end

  // tdi enters the top bit of whichever register length is selected.
  always_comb begin
    w_dr_shift = 35'd0;
    case (w_sel)
      DR_IDCODE: w_dr_shift = {3'b000, r_tdi_s2, r_dr[31:1]};
      DR_BYPASS: w_dr_shift = {34'd0, r_tdi_s2};
      default:   w_dr_shift = {r_tdi_s2, r_dr[34:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir         <= IR_IDCODE;
      r_ir_sr      <= '0;
      r_dr         <= 35'd0;
      r_tdo        <= 1'b0;
      r_req        <= 1'b0;
      r_abort      <= 1'b0;
      r_req_apndp  <= 1'b0;
      r_req_addr32 <= 2'b00;
      r_req_rnw    <= 1'b0;
      r_req_wdata  <= 32'd0;
    end else begin
      r_req   <= 1'b0;
      r_abort <= 1'b0;
      if (w_state == TAP_TLR) r_ir <= IR_IDCODE;
      if (w_rise) begin
        case (w_state)
          TAP_CAPIR: r_ir_sr <= IR_CAPTURE;
          TAP_SHIR:  r_ir_sr <= {r_tdi_s2, r_ir_sr[IRLEN-1:1]};
          TAP_UPDIR: r_ir    <= r_ir_sr;
          TAP_CAPDR: r_dr    <= w_dr_capture;
          TAP_SHDR:  r_dr    <= w_dr_shift;
          TAP_UPDDR: begin
            case (w_sel)
              DR_DPACC, DR_APACC: begin
                r_req        <= 1'b1;
                r_req_apndp  <= (w_sel == DR_APACC);
                r_req_addr32 <= r_dr[2:1];
                r_req_rnw    <= r_dr[0];
                r_req_wdata  <= r_dr[34:3];
              end
              DR_ABORT: begin
                r_abort     <= 1'b1;
                r_req_wdata <= r_dr[34:3];
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      if (w_fall) begin
        if (w_state == TAP_SHDR)      r_tdo <= r_dr[0];
        else if (w_state == TAP_SHIR) r_tdo <= r_ir_sr[0];
        else                          r_tdo <= 1'b0;
      end
    end
  end

  assign tdo        = r_tdo;
  assign ir         = r_ir;
  assign tap_state  = w_state_bits;
  assign req        = r_req;
  assign req_apndp  = r_req_apndp;
  assign req_addr32 = r_req_addr32;
  assign req_rnw    = r_req_rnw;
  assign req_wdata  = r_req_wdata;
  assign abort      = r_abort;

endmodule
